hssim_frame_ctrl: RTL and testbench

- Frame sequencer for the HSSIM fusion datapath.
- Joins the three edge-map streams (old, avg, new) into one lock-step beat stream.
- Generates the datapath's global stall, holds the core in reset between frames, and feeds zero beats after the last input beat to flush the pipeline.
- Tags the fused delta-map output with valid/last and applies output backpressure.
- Sits between the stream DMA and the HSSIM core; carries control only, no pixel data.

---
 rtl/hssim_pkg.sv | 18 +
 rtl/hssim_frame_ctrl_if.sv | 25 ++
 rtl/hssim_stream_join.sv | 21 ++
 rtl/hssim_frame_ctrl.sv | 106 ++++++++++
 tb/tb_hssim_frame_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hssim_pkg.sv
// HSSIM shared types and frame geometry defaults.
// Used by the frame controller, the core and the bench.
package hssim_pkg;

    localparam int DEF_PIXELS_PER_BEAT = 16;
    localparam int DEF_IMAGE_DIM       = 512;
    localparam int DEF_PIPE_LAT        = 140;
    localparam int DEF_BEATS           =
        DEF_IMAGE_DIM * DEF_IMAGE_DIM / DEF_PIXELS_PER_BEAT;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/hssim_frame_ctrl_if.sv
// Stream handshake bundle between DMA, frame controller and sink.
// slave = frame controller view, master = environment view.
interface hssim_frame_ctrl_if;

    logic s_old_valid;
    logic s_avg_valid;
    logic s_new_valid;
    logic s_old_ready;
    logic s_avg_ready;
    logic s_new_ready;
    logic m_valid;
    logic m_last;
    logic m_ready;

    modport slave (
        input  s_old_valid, s_avg_valid, s_new_valid, m_ready,
        output s_old_ready, s_avg_ready, s_new_ready, m_valid, m_last
    );

    modport master (
        output s_old_valid, s_avg_valid, s_new_valid, m_ready,
        input  s_old_ready, s_avg_ready, s_new_ready, m_valid, m_last
    );

endinterface

// File: rtl/hssim_stream_join.sv
// Three-way lock-step join of the edge-map streams,
// gated by free output space; also passes zero beats in flush.
module hssim_stream_join (
    input  logic join_en,
    input  logic pass_en,
    input  logic out_free,
    input  logic old_valid,
    input  logic avg_valid,
    input  logic new_valid,
    output logic adv,
    output logic in_ready
);

    logic all_valid;

    assign all_valid = old_valid & avg_valid & new_valid;
    assign adv       = out_free & ((join_en & all_valid) | pass_en);
    // Ready only follows a full join, so no stream is consumed alone.
    assign in_ready  = adv & join_en;

endmodule

// File: rtl/hssim_frame_ctrl.sv
// HSSIM frame sequencer: joins input maps, drives core stall/reset,
// flushes the pipeline and tags the delta-map output beats.
module hssim_frame_ctrl
    import hssim_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = DEF_PIXELS_PER_BEAT,
    parameter int IMAGE_DIM       = DEF_IMAGE_DIM,
    parameter int PIPE_LAT        = DEF_PIPE_LAT
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               start,
    hssim_frame_ctrl_if.slave  bus,
    output logic               core_stall,
    output logic               core_resetn,
    output logic               zero_fill,
    output logic               busy,
    output logic               done
);

    localparam int BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int TOTAL = BEATS + PIPE_LAT;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CW-1:0] ADV_MAX   = CW'(TOTAL);
    localparam logic [CW-1:0] LAT       = CW'(PIPE_LAT);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] adv_cnt;
    logic [CW-1:0] out_cnt;
    logic          m_valid_q;
    logic          out_free;
    logic          adv;
    logic          in_ready;
    logic          produce;
    logic          hs;
    logic          pass_en;

    assign out_free = ~m_valid_q | bus.m_ready;
    // Once every beat is in flight the flush stops feeding zeros.
    assign pass_en  = (state == FLUSH) && (adv_cnt != ADV_MAX);

    hssim_stream_join u_join (
        .join_en   (state == RUN),
        .pass_en   (pass_en),
        .out_free  (out_free),
        .old_valid (bus.s_old_valid),
        .avg_valid (bus.s_avg_valid),
        .new_valid (bus.s_new_valid),
        .adv       (adv),
        .in_ready  (in_ready)
    );

    assign produce = adv && (adv_cnt >= LAT);
    assign hs      = m_valid_q & bus.m_ready;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (adv && adv_cnt == LAST_BEAT) state_n = FLUSH;
            FLUSH:   if (hs && out_cnt == LAST_BEAT) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            core_resetn <= 1'b0;
            m_valid_q   <= 1'b0;
            adv_cnt     <= '0;
            out_cnt     <= '0;
        end else begin
            state       <= state_n;
            core_resetn <= (state_n != IDLE);
            if (produce)
                m_valid_q <= 1'b1;
            else if (bus.m_ready)
                m_valid_q <= 1'b0;
            if (state == IDLE) begin
                adv_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (adv && adv_cnt != ADV_MAX)
                    adv_cnt <= adv_cnt + CW'(1);
                if (hs)
                    out_cnt <= out_cnt + CW'(1);
            end
        end
    end

    assign core_stall      = ~adv;
    assign zero_fill       = (state == FLUSH);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign bus.m_valid     = m_valid_q;
    assign bus.m_last      = m_valid_q & (out_cnt == LAST_BEAT);
    assign bus.s_old_ready = in_ready;
    assign bus.s_avg_ready = in_ready;
    assign bus.s_new_ready = in_ready;

endmodule

// File: tb/tb_hssim_frame_ctrl.sv
// Self-checking bench for hssim_frame_ctrl on an 8x8 image,
// 4 pixels per beat (16 beats) and a 3-advance pipeline.
module tb_hssim_frame_ctrl;

    localparam int PPB      = 4;
    localparam int DIM      = 8;
    localparam int PIPE_LAT = 3;
    localparam int BEATS    = DIM * DIM / PPB;
    localparam int TOTAL    = BEATS + PIPE_LAT;

    logic clk = 1'b0;
    logic aresetn;
    logic start;
    logic core_stall, core_resetn, zero_fill, busy, done;

    hssim_frame_ctrl_if bus ();

    hssim_frame_ctrl #(
        .PIXELS_PER_BEAT (PPB),
        .IMAGE_DIM       (DIM),
        .PIPE_LAT        (PIPE_LAT)
    ) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .start       (start),
        .bus         (bus),
        .core_stall  (core_stall),
        .core_resetn (core_resetn),
        .zero_fill   (zero_fill),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: frame progress as advance/output counts
    int n_adv, n_out;
    bit active, done_ph;

    int bad_stall, bad_ready, bad_zf, bad_mv, bad_last, bad_ctl;
    int o_adv, o_zf, o_out, o_done, in_old, in_avg, in_new;
    int first_mv_adv, last_at, cyc;
    int first_in_cyc, last_in_cyc, last_hs_cyc, done_cyc;
    logic obs_stall, obs_rdy, obs_mv, obs_last;
    logic obs_done, obs_busy, obs_crn, obs_zf;

    function automatic int pending();
        return ((n_adv > PIPE_LAT) ? n_adv - PIPE_LAT : 0) - n_out;
    endfunction

    task automatic clear_stats();
        bad_stall = 0; bad_ready = 0; bad_zf = 0;
        bad_mv = 0; bad_last = 0; bad_ctl = 0;
        o_adv = 0; o_zf = 0; o_out = 0; o_done = 0;
        in_old = 0; in_avg = 0; in_new = 0;
        first_mv_adv = -1; last_at = -1;
        first_in_cyc = -1; last_in_cyc = -1;
        last_hs_cyc = -1; done_cyc = -1;
    endtask

    task automatic tick(input logic ov, input logic av, input logic nv,
                        input logic mr, input logic st);
        int pend;
        bit exp_adv, exp_rdy, idle_m, hs_m;
        bus.s_old_valid = ov;
        bus.s_avg_valid = av;
        bus.s_new_valid = nv;
        bus.m_ready = mr;
        start = st;
        #1;
        pend = pending();
        exp_adv = 1'b0;
        if (active && n_adv < BEATS)
            exp_adv = ov & av & nv & ((pend == 0) | mr);
        else if (active && n_adv < TOTAL)
            exp_adv = (pend == 0) | mr;
        exp_rdy = exp_adv && (n_adv < BEATS);
        obs_stall = core_stall;
        obs_rdy = bus.s_old_ready;
        obs_mv = bus.m_valid;
        obs_last = bus.m_last;
        obs_done = done;
        obs_busy = busy;
        obs_crn = core_resetn;
        obs_zf = zero_fill;
        if (obs_stall !== !exp_adv) bad_stall++;
        if (bus.s_old_ready !== exp_rdy || bus.s_avg_ready !== exp_rdy
            || bus.s_new_ready !== exp_rdy) bad_ready++;
        if (obs_zf !== (active && n_adv >= BEATS)) bad_zf++;
        if (obs_mv !== (pend == 1)) bad_mv++;
        if (obs_last !== (pend == 1 && n_out == BEATS - 1)) bad_last++;
        if (obs_done !== done_ph || obs_busy !== (active | done_ph)
            || obs_crn !== (active | done_ph)) bad_ctl++;
        if (obs_mv === 1'b1 && first_mv_adv < 0) first_mv_adv = o_adv;
        if (obs_stall === 1'b0) begin
            o_adv++;
            if (obs_zf === 1'b1) o_zf++;
        end
        if (bus.s_old_ready === 1'b1 && ov) begin
            in_old++;
            if (first_in_cyc < 0) first_in_cyc = cyc;
            last_in_cyc = cyc;
        end
        if (bus.s_avg_ready === 1'b1 && av) in_avg++;
        if (bus.s_new_ready === 1'b1 && nv) in_new++;
        if (obs_mv === 1'b1 && mr) begin
            o_out++;
            last_hs_cyc = cyc;
            if (obs_last === 1'b1) last_at = o_out;
        end
        if (obs_done === 1'b1) begin
            o_done++;
            done_cyc = cyc;
        end
        idle_m = !active && !done_ph;
        hs_m = (pend == 1) && mr;
        @(posedge clk);
        if (exp_adv) n_adv++;
        if (hs_m) n_out++;
        if (done_ph) begin
            done_ph = 1'b0;
        end else if (active && hs_m && n_out == BEATS) begin
            active = 1'b0;
            done_ph = 1'b1;
        end else if (idle_m && st) begin
            active = 1'b1;
            n_adv = 0;
            n_out = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        #1;
        active = 1'b0;
        done_ph = 1'b0;
        n_adv = 0;
        n_out = 0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        bus.s_old_valid = 1'b1;
        bus.s_avg_valid = 1'b1;
        bus.s_new_valid = 1'b1;
        bus.m_ready = 1'b1;
        start = 1'b0;
        apply_reset();
        got = {core_stall, core_resetn, zero_fill, bus.m_valid,
               bus.m_last, done, busy, bus.s_old_ready};
        checks++;
        if (got !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_values got=%b required=10000000", got);
        end
        checks++;
        if ({bus.s_avg_ready, bus.s_new_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got=%b required=00",
                     {bus.s_avg_ready, bus.s_new_ready});
        end
        @(negedge clk);
        aresetn = 1'b1;
        clear_stats();
        tick(1, 1, 1, 1, 0);
        tick(1, 1, 1, 1, 0);
        checks++;
        if (obs_rdy !== 1'b0 || obs_busy !== 1'b0 || obs_stall !== 1'b1) begin
            errors++;
            $display("FAIL idle_no_start rdy=%b busy=%b stall=%b required 0 0 1",
                     obs_rdy, obs_busy, obs_stall);
        end
    endtask

    task automatic test_full_throughput();
        clear_stats();
        tick(1, 1, 1, 1, 1);
        for (int i = 0; i < 100 && o_done == 0; i++) tick(1, 1, 1, 1, 0);
        tick(1, 1, 1, 1, 0);
        checks++;
        if (o_done !== 1) begin
            errors++;
            $display("FAIL full_done_count got=%0d required=1", o_done);
        end
        checks++;
        if (in_old !== 16 || in_avg !== 16 || in_new !== 16) begin
            errors++;
            $display("FAIL full_inputs got=%0d/%0d/%0d required=16",
                     in_old, in_avg, in_new);
        end
        checks++;
        if (last_in_cyc - first_in_cyc !== 15) begin
            errors++;
            $display("FAIL full_in_span got=%0d required=15",
                     last_in_cyc - first_in_cyc);
        end
        checks++;
        if (first_mv_adv !== 4) begin
            errors++;
            $display("FAIL full_first_valid got=%0d required=4", first_mv_adv);
        end
        checks++;
        if (o_out !== 16 || last_at !== 16) begin
            errors++;
            $display("FAIL full_outputs got=%0d last_at=%0d required=16 16",
                     o_out, last_at);
        end
        checks++;
        if (done_cyc - last_hs_cyc !== 1) begin
            errors++;
            $display("FAIL full_done_delay got=%0d required=1",
                     done_cyc - last_hs_cyc);
        end
        checks++;
        if (o_adv !== 19 || o_zf !== 3) begin
            errors++;
            $display("FAIL full_advances got=%0d zf=%0d required=19 3",
                     o_adv, o_zf);
        end
        checks++;
        if (bad_stall + bad_ready + bad_zf + bad_mv + bad_last + bad_ctl !== 0) begin
            errors++;
            $display("FAIL full_model stall=%0d rdy=%0d zf=%0d mv=%0d last=%0d ctl=%0d required 0",
                     bad_stall, bad_ready, bad_zf, bad_mv, bad_last, bad_ctl);
        end
    endtask

    task automatic test_staggered();
        logic nv;
        clear_stats();
        tick(1, 1, 1, 1, 1);
        for (int i = 0; i < 150 && o_done == 0; i++) begin
            nv = (cyc % 2 == 1);
            tick(1, 1, nv, 1, 0);
            if (!nv && obs_busy === 1'b1 && obs_zf === 1'b0) begin
                checks++;
                if (obs_stall !== 1'b1 || obs_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL stagger_gap cyc=%0d stall=%b rdy=%b required 1 0",
                             cyc, obs_stall, obs_rdy);
                end
            end
        end
        tick(1, 1, 1, 1, 0);
        checks++;
        if (in_old !== 16 || in_avg !== 16 || in_new !== 16 || o_done !== 1) begin
            errors++;
            $display("FAIL stagger_inputs got=%0d/%0d/%0d done=%0d required=16 1",
                     in_old, in_avg, in_new, o_done);
        end
        checks++;
        if (bad_stall + bad_ready + bad_zf + bad_mv + bad_last + bad_ctl !== 0) begin
            errors++;
            $display("FAIL stagger_model stall=%0d rdy=%0d zf=%0d mv=%0d last=%0d ctl=%0d required 0",
                     bad_stall, bad_ready, bad_zf, bad_mv, bad_last, bad_ctl);
        end
    endtask

    task automatic test_backpressure();
        int bp;
        logic mr;
        bp = 0;
        clear_stats();
        tick(1, 1, 1, 1, 1);
        for (int i = 0; i < 150 && o_done == 0; i++) begin
            mr = !(o_out >= 6 && bp < 5);
            if (!mr) bp++;
            tick(1, 1, 1, mr, 0);
            if (!mr) begin
                checks++;
                if (obs_mv !== 1'b1 || obs_stall !== 1'b1 || obs_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d mv=%b stall=%b rdy=%b required 1 1 0",
                             cyc, obs_mv, obs_stall, obs_rdy);
                end
            end
        end
        tick(1, 1, 1, 1, 0);
        checks++;
        if (o_out !== 16 || last_at !== 16 || o_done !== 1) begin
            errors++;
            $display("FAIL bp_outputs got=%0d last_at=%0d done=%0d required=16 16 1",
                     o_out, last_at, o_done);
        end
        checks++;
        if (bad_stall + bad_ready + bad_zf + bad_mv + bad_last + bad_ctl !== 0) begin
            errors++;
            $display("FAIL bp_model stall=%0d rdy=%0d zf=%0d mv=%0d last=%0d ctl=%0d required 0",
                     bad_stall, bad_ready, bad_zf, bad_mv, bad_last, bad_ctl);
        end
    endtask

    task automatic test_start_ignored();
        bit gap;
        gap = 1'b0;
        clear_stats();
        for (int i = 0; i < 200 && o_done < 2; i++) begin
            tick(1, 1, 1, 1, 1);
            if (o_done == 1 && obs_busy === 1'b0 && obs_crn === 1'b0) gap = 1'b1;
        end
        tick(1, 1, 1, 1, 0);
        checks++;
        if (o_done !== 2 || o_adv !== 38) begin
            errors++;
            $display("FAIL start_frames done=%0d adv=%0d required=2 38",
                     o_done, o_adv);
        end
        checks++;
        if (gap !== 1'b1) begin
            errors++;
            $display("FAIL start_reset_gap got=%b required=1", gap);
        end
        checks++;
        if (bad_stall + bad_ready + bad_zf + bad_mv + bad_last + bad_ctl !== 0) begin
            errors++;
            $display("FAIL start_model stall=%0d rdy=%0d zf=%0d mv=%0d last=%0d ctl=%0d required 0",
                     bad_stall, bad_ready, bad_zf, bad_mv, bad_last, bad_ctl);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        clear_stats();
        tick(1, 1, 1, 1, 1);
        for (int i = 0; i < 50 && n_adv < 9; i++) tick(1, 1, 1, 1, 0);
        apply_reset();
        got = {core_stall, core_resetn, bus.m_valid, busy,
               bus.s_old_ready, zero_fill};
        checks++;
        if (got !== 6'b100000) begin
            errors++;
            $display("FAIL midreset_values got=%b required=100000", got);
        end
        @(negedge clk);
        aresetn = 1'b1;
        clear_stats();
        tick(1, 1, 1, 1, 1);
        for (int i = 0; i < 100 && o_done == 0; i++) tick(1, 1, 1, 1, 0);
        tick(1, 1, 1, 1, 0);
        checks++;
        if (first_mv_adv !== 4 || o_out !== 16 || o_adv !== 19) begin
            errors++;
            $display("FAIL midreset_frame first=%0d out=%0d adv=%0d required=4 16 19",
                     first_mv_adv, o_out, o_adv);
        end
        checks++;
        if (bad_stall + bad_ready + bad_zf + bad_mv + bad_last + bad_ctl !== 0) begin
            errors++;
            $display("FAIL midreset_model stall=%0d rdy=%0d zf=%0d mv=%0d last=%0d ctl=%0d required 0",
                     bad_stall, bad_ready, bad_zf, bad_mv, bad_last, bad_ctl);
        end
    endtask

    task automatic test_last_hold();
        clear_stats();
        tick(1, 1, 1, 1, 1);
        for (int i = 0; i < 100 && !(pending() == 1 && n_out == BEATS - 1); i++)
            tick(1, 1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 1, 0, 0);
            checks++;
            if (obs_last !== 1'b1 || obs_zf !== 1'b1 || obs_done !== 1'b0) begin
                errors++;
                $display("FAIL last_hold i=%0d last=%b zf=%b done=%b required 1 1 0",
                         i, obs_last, obs_zf, obs_done);
            end
        end
        tick(1, 1, 1, 1, 0);
        tick(1, 1, 1, 1, 0);
        checks++;
        if (obs_done !== 1'b1) begin
            errors++;
            $display("FAIL last_done got=%b required=1", obs_done);
        end
        tick(1, 1, 1, 1, 0);
        checks++;
        if (obs_busy !== 1'b0 || o_out !== 16) begin
            errors++;
            $display("FAIL last_idle busy=%b out=%0d required 0 16", obs_busy, o_out);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 2; f++) begin
            clear_stats();
            tick(1, 1, 1, 1, 1);
            for (int i = 0; i < 400 && o_done == 0; i++)
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 1) == 1);
            tick(0, 0, 0, 1, 0);
            checks++;
            if (o_done !== 1 || o_out !== 16 || o_adv !== 19 || in_new !== 16) begin
                errors++;
                $display("FAIL random_frame f=%0d done=%0d out=%0d adv=%0d in=%0d required 1 16 19 16",
                         f, o_done, o_out, o_adv, in_new);
            end
            checks++;
            if (bad_stall + bad_ready + bad_zf + bad_mv + bad_last + bad_ctl !== 0) begin
                errors++;
                $display("FAIL random_model stall=%0d rdy=%0d zf=%0d mv=%0d last=%0d ctl=%0d required 0",
                         bad_stall, bad_ready, bad_zf, bad_mv, bad_last, bad_ctl);
            end
        end
    endtask

    initial begin
        cyc = 0;
        clear_stats();
        test_reset();
        test_full_throughput();
        test_staggered();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_last_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
